// File: rtl/seg7_scan_drv.sv
// seg7_scan_drv: 8-digit multiplexed 7-segment driver with frame-aligned shadow capture and blink
module seg7_scan_drv #(
    parameter int SCAN_DIV  = 17,
    parameter int BLINK_DIV = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        EN,
    input  logic [31:0] Disp_num,
    input  logic [7:0]  LE,
    input  logic [7:0]  point,
    output logic [7:0]  AN,
    output logic [7:0]  SEGMENT,
    output logic        frame_done
);
    localparam int SW = SCAN_DIV + 3;
    localparam logic [111:0] HEX = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
                                    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
    logic [SW-1:0]        scan_cnt;
    logic [BLINK_DIV-1:0] blink_cnt;
    logic                 blink_ph;
    logic [31:0]          sh_num;
    logic [7:0]           sh_le, sh_pt;
    logic [2:0]           d;
    logic [3:0]           nib;
    logic                 wrap;
    logic [7:0]           an_nx, seg_nx;
    always_comb begin
        d      = scan_cnt[SW-1:SCAN_DIV];
        nib    = sh_num[{d, 2'b00} +: 4];
        wrap   = &scan_cnt;
        an_nx  = ~(8'b1 << d);
        seg_nx = (blink_ph && sh_le[d]) ? 8'hFF : {~sh_pt[d], HEX[7*int'(nib) +: 7]};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt   <= '0;
            blink_cnt  <= '0;
            blink_ph   <= 1'b0;
            sh_num     <= '0;
            sh_le      <= '0;
            sh_pt      <= '0;
            AN         <= 8'hFF;
            SEGMENT    <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            scan_cnt   <= scan_cnt + SW'(1);
            blink_cnt  <= blink_cnt + BLINK_DIV'(1);
            blink_ph   <= blink_ph ^ (&blink_cnt);
            AN         <= an_nx;
            SEGMENT    <= seg_nx;
            frame_done <= wrap;
            if (wrap && EN) begin
                sh_num <= Disp_num;
                sh_le  <= LE;
                sh_pt  <= point;
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_drv.sv
// tb_seg7_scan_drv: directed frame-by-frame checks of seg7_scan_drv at reduced divider sizes
module tb_seg7_scan_drv;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        EN = 1'b0;
    logic [31:0] Disp_num = '0;
    logic [7:0]  LE = '0;
    logic [7:0]  point = '0;
    logic [7:0]  AN, SEGMENT;
    logic        frame_done;
    int          t = 0;
    int          n_chk = 0;
    int          n_bad = 0;

    typedef struct {
        logic [31:0] num;
        logic [7:0]  le;
        logic [7:0]  pt;
        logic        en;
        logic [63:0] seg;
        logic [7:0]  blank;
    } vec_t;
    vec_t v[7];

    seg7_scan_drv #(.SCAN_DIV(2), .BLINK_DIV(6)) dut (
        .clk(clk), .rst(rst), .EN(EN), .Disp_num(Disp_num), .LE(LE), .point(point),
        .AN(AN), .SEGMENT(SEGMENT), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic skip(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0d got %h expected %h", nm, t, act, exp);
        end
    endtask

    // Expects t%32==0 on entry; the blank mask applies only while the blink phase seen by the output stage is 1
    task automatic check_frame(input string nm, input logic [63:0] seg, input logic [7:0] blank);
        logic [7:0] es;
        int dd, ph;
        for (int i = 1; i <= 32; i++) begin
            tick();
            dd = (i - 1) / 4;
            ph = ((t - 1) / 64) % 2;
            es = (ph == 1 && blank[dd]) ? 8'hFF : seg[8*dd +: 8];
            chk({nm, "_an"}, AN, ~(8'b1 << dd));
            chk({nm, "_seg"}, SEGMENT, es);
            chk({nm, "_fd"}, {7'b0, frame_done}, {7'b0, i == 32});
        end
    endtask

    initial begin
        v[0] = '{32'h89ABCDEF, 8'h00, 8'h00, 1'b1, 64'h80908883C6A1868E, 8'h00};
        v[1] = '{32'h89ABCDEF, 8'h00, 8'h05, 1'b1, 64'h80908883C621860E, 8'h00};
        v[2] = '{32'h89ABCDEF, 8'h80, 8'h00, 1'b1, 64'h80908883C6A1868E, 8'h80};
        v[3] = '{32'h89ABCDEF, 8'h80, 8'h00, 1'b1, 64'h80908883C6A1868E, 8'h80};
        v[4] = '{32'h89ABCDEF, 8'hFF, 8'hFF, 1'b1, 64'h001008034621060E, 8'hFF};
        v[5] = '{32'h00000000, 8'h00, 8'h00, 1'b0, 64'h001008034621060E, 8'hFF};
        v[6] = '{32'h00000000, 8'h00, 8'h00, 1'b1, 64'hC0C0C0C0C0C0C0C0, 8'h00};

        // Load non-zero shadows, then reset mid-frame to prove everything clears
        skip(2);
        rst = 1'b0; Disp_num = 32'hFFFFFFFF; point = 8'hFF; EN = 1'b1;
        skip(40);
        rst = 1'b1;
        tick();
        chk("rst_an", AN, 8'hFF);
        chk("rst_seg", SEGMENT, 8'hFF);
        chk("rst_fd", {7'b0, frame_done}, 8'h00);
        EN = 1'b0; Disp_num = '0; point = '0;
        skip(2);
        t = 0;
        chk("rst_end_an", AN, 8'hFF);
        chk("rst_end_seg", SEGMENT, 8'hFF);
        rst = 1'b0;
        tick();
        chk("post_rst_an", AN, 8'hFE);
        chk("post_rst_seg", SEGMENT, 8'hC0);
        chk("post_rst_fd", {7'b0, frame_done}, 8'h00);
        skip(4);
        chk("post_rst_d1_an", AN, 8'hFD);
        chk("post_rst_d1_seg", SEGMENT, 8'hC0);
        skip(27);

        for (int k = 0; k < 7; k++) begin
            Disp_num = v[k].num; LE = v[k].le; point = v[k].pt; EN = v[k].en;
            skip(32);
            check_frame($sformatf("vec%0d", k), v[k].seg, v[k].blank);
        end

        // Mid-frame change with EN=1 waits for the frame boundary
        skip(10);
        Disp_num = 32'hFFFFFFFF; EN = 1'b1;
        for (int i = 0; i < 22; i++) begin
            tick();
            chk("gate_hold_seg", SEGMENT, 8'hC0);
        end
        chk("gate_fd", {7'b0, frame_done}, 8'h01);
        check_frame("gate_new", {8{8'h8E}}, 8'h00);

        // Mid-frame change with EN=0 never reaches the display
        skip(6);
        Disp_num = '0; EN = 1'b0;
        skip(26);
        check_frame("gate_off", {8{8'h8E}}, 8'h00);

        // Input change exactly on the capture edge
        skip(31);
        Disp_num = 32'h00000001; EN = 1'b1;
        tick();
        chk("coin_last_an", AN, 8'h7F);
        chk("coin_last_seg", SEGMENT, 8'h8E);
        chk("coin_fd", {7'b0, frame_done}, 8'h01);
        check_frame("coin_new", {{7{8'hC0}}, 8'hF9}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/seg7_scan_drv.md
Name: seg7_scan_drv

Overview:
- Time-multiplexed driver for the board's 8-digit common-anode 7-segment display.
- Sits directly downstream of the 8-channel display multiplexer and consumes its Disp_num[31:0], LE_out[7:0] and point_out[7:0].
- Captures those values into shadow registers only at frame boundaries, so the display never tears.
- Scans one digit at a time, hex-decodes the nibble, applies decimal point and per-digit blink, and drives active-low anode/segment pins.

Parameters:
SCAN_DIV, 17, digit advances every 2^SCAN_DIV clk cycles; frame = 8*2^SCAN_DIV cycles
BLINK_DIV, 25, blink phase toggles every 2^BLINK_DIV clk cycles

Ports:
clk  input  1  system clock; only clock
rst  input  1  synchronous, active-high reset
EN  input  1  enables shadow capture at frame boundary
Disp_num  input  32  hex data; digit i = Disp_num[4i+3:4i], digit 0 rightmost
LE  input  8  per-digit blink enable, 1 = blink digit i
point  input  8  per-digit decimal point, 1 = dp lit
AN  output  8  anode enables, active low, AN[i] selects digit i
SEGMENT  output  8  {dp,g,f,e,d,c,b,a}, active low
frame_done  output  1  one-cycle pulse on last cycle of each frame

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on posedge clk.
- Reset values:
  - scan_cnt (SCAN_DIV+3 bits) = 0, blink_cnt (BLINK_DIV bits) = 0, blink_ph = 0.
  - Shadow data/LE/point = 0.
  - AN = 8'hFF, SEGMENT = 8'hFF, frame_done = 0.
- Reset asserted mid-frame: the next edge returns everything to these values. Scanning restarts at digit 0.
- scan_cnt increments every cycle and wraps naturally.
  - Digit index d = scan_cnt[SCAN_DIV+2:SCAN_DIV].
- frame_done is registered. It is 1 in the cycle after scan_cnt == all-ones (i.e. aligned with the wrap to 0).
- Shadow capture: on an edge where scan_cnt == all-ones and EN == 1, the shadows load Disp_num, LE and point.
  - If EN == 0 at that edge, the shadows hold.
  - Inputs are never sampled at any other time.
  - After reset, all-zero shadows are displayed until the first capture.
- blink_cnt increments every cycle. blink_ph toggles on the edge where blink_cnt == all-ones.
- Output stage is registered, latency 1: AN/SEGMENT in cycle t+1 reflect d and the shadows at cycle t.
  - AN = ~(8'b1 << d), exactly one anode low.
  - If blink_ph == 1 and shadow LE[d] == 1: SEGMENT = 8'hFF (digit blank, dp included). The anode is still asserted.
  - Otherwise SEGMENT[6:0] = hex decode of nibble d, and SEGMENT[7] = ~shadow point[d].
- Hex decode, {g..a}, active low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - With dp off these give SEGMENT 0=C0 ... F=8E.
- Simultaneous events: a capture edge, a blink toggle and a digit advance may coincide. In that case the next output uses the pre-capture shadows and the pre-toggle blink_ph (all registers update on the same edge).

Test Plan:
(Sim params: SCAN_DIV=2, BLINK_DIV=6; digit period 4, frame 32 cycles, blink half-period 64.)
- Reset: hold rst 3 cycles, mid-frame -> AN=FF, SEGMENT=FF and frame_done=0 the cycle after rst; first post-reset cycles show d=0 with SEGMENT=C0, AN=FE.
- Hex scan: EN=1, Disp_num=32'h89ABCDEF, LE=0, point=0, wait one frame -> next frame shows digits 0..7 as SEGMENT 8E,86,A1,C6,83,88,90,80 with AN FE,FD,FB,F7,EF,DF,BF,7F; each held 4 cycles.
- Point: point=8'h05 -> digits 0 and 2 show SEGMENT[7]=0 (digit 0 = 0E for F); all others have SEGMENT[7]=1.
- Blink: LE=8'h80 -> digit 7 SEGMENT=FF during blink_ph=1 intervals (64 cycles) and 80 otherwise; other digits are unaffected.
- Capture gating: change Disp_num to 32'h00000000 mid-frame with EN=1 -> display changes only after the frame_done edge. Repeat with EN=0 -> display never changes.
- Coincidence: align an input change with scan_cnt==all-ones -> the new value appears from the first output cycle of the next frame, never partially within a frame.
